// File: rtl/ibex_rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_wb_arbiter_if
// Description : Writeback requester handshakes and register-file write port
//               bundle for ibex_rf_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ibex_rf_wb_arbiter_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 wa_valid_i;
    logic [4:0]           wa_addr_i;
    logic [DataWidth-1:0] wa_data_i;
    logic                 wa_ready_o;
    logic                 wb_valid_i;
    logic [4:0]           wb_addr_i;
    logic [DataWidth-1:0] wb_data_i;
    logic                 wb_ready_o;
    logic                 rf_we_o;
    logic [4:0]           rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic                 busy_o;
    logic                 err_o;

    // Arbiter side
    modport slave (
        input  wa_valid_i, wa_addr_i, wa_data_i,
        output wa_ready_o,
        input  wb_valid_i, wb_addr_i, wb_data_i,
        output wb_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, err_o
    );

    // Requester / register-file side
    modport master (
        output wa_valid_i, wa_addr_i, wa_data_i,
        input  wa_ready_o,
        output wb_valid_i, wb_addr_i, wb_data_i,
        input  wb_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/ibex_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_wb_arbiter
// Description : Round-robin arbiter sharing the register-file write port
//               between ALU (A) and LSU (B) writeback. Optional post-reset
//               clear sequence enabled by macro IBEX_RF_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_wb_arbiter #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ibex_rf_wb_arbiter_if.slave    bus
);

    logic                 r_we;
    logic [4:0]           r_waddr;
    logic [DataWidth-1:0] r_wdata;
    logic                 r_err;
    logic                 r_last_b;
    logic                 w_run;
    logic                 w_grant_a;
    logic                 w_grant_b;
    logic [4:0]           w_sel_addr;
    logic [DataWidth-1:0] w_sel_data;
    logic                 w_illegal;

`ifdef IBEX_RF_CLEAR_EN
    localparam int unsigned c_num_regs  = RV32E ? 16 : 32;
    localparam logic [4:0]  c_last_addr = 5'(c_num_regs - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t     r_state;
    logic [4:0] r_cnt;

    assign w_run       = (r_state == RUN);
    assign bus.busy_o  = (r_state == CLEAR);
`else
    logic w_unused;

    assign w_run       = 1'b1;
    assign bus.busy_o  = 1'b0;
    assign w_unused    = ^WordZeroVal;
`endif

    // On a tie, the requester that did not win last time gets the port.
    assign w_grant_a = w_run & bus.wa_valid_i & (~bus.wb_valid_i | r_last_b);
    assign w_grant_b = w_run & bus.wb_valid_i & (~bus.wa_valid_i | ~r_last_b);

    assign w_sel_addr = w_grant_a ? bus.wa_addr_i : bus.wb_addr_i;
    assign w_sel_data = w_grant_a ? bus.wa_data_i : bus.wb_data_i;
    assign w_illegal  = RV32E & w_sel_addr[4];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_last_b <= 1'b1;
`ifdef IBEX_RF_CLEAR_EN
            r_state  <= CLEAR;
            r_cnt    <= 5'd1;
`endif
        end else begin
`ifdef IBEX_RF_CLEAR_EN
            if (r_state == CLEAR) begin
                r_we    <= 1'b1;
                r_waddr <= r_cnt;
                r_wdata <= WordZeroVal;
                r_err   <= 1'b0;
                r_cnt   <= r_cnt + 5'd1;
                if (r_cnt == c_last_addr) begin
                    r_state <= RUN;
                end
            end else
`endif
            begin
                r_we  <= 1'b0;
                r_err <= 1'b0;
                if (w_grant_a | w_grant_b) begin
                    // x0 and out-of-range targets are consumed but never written.
                    r_we     <= ~w_illegal & (w_sel_addr != 5'd0);
                    r_err    <= w_illegal;
                    r_waddr  <= w_sel_addr;
                    r_wdata  <= w_sel_data;
                    r_last_b <= w_grant_b;
                end
            end
        end
    end

    assign bus.wa_ready_o = w_grant_a;
    assign bus.wb_ready_o = w_grant_b;
    assign bus.rf_we_o    = r_we;
    assign bus.rf_waddr_o = r_waddr;
    assign bus.rf_wdata_o = r_wdata;
    assign bus.err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_rf_wb_arbiter
// Description : Directed scoreboard bench for ibex_rf_wb_arbiter (RV32I and
//               RV32E instances driven with identical stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_rf_wb_arbiter;

    localparam int DW = 32;
`ifdef IBEX_RF_CLEAR_EN
    localparam logic c_clr = 1'b1;
`else
    localparam logic c_clr = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [4:0]    addr;
        logic [DW-1:0] data;
        logic          err;
        bit            chk_ad;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    logic [4:0]    last_addr = '0;
    logic [DW-1:0] last_data = '0;
    bit            known     = 1'b1;

    always #5 clk = ~clk;

    ibex_rf_wb_arbiter_if #(.DataWidth(DW)) bus0 ();
    ibex_rf_wb_arbiter_if #(.DataWidth(DW)) bus1 ();

    assign bus1.wa_valid_i = bus0.wa_valid_i;
    assign bus1.wa_addr_i  = bus0.wa_addr_i;
    assign bus1.wa_data_i  = bus0.wa_data_i;
    assign bus1.wb_valid_i = bus0.wb_valid_i;
    assign bus1.wb_addr_i  = bus0.wb_addr_i;
    assign bus1.wb_data_i  = bus0.wb_data_i;

    ibex_rf_wb_arbiter #(.RV32E(1'b0), .DataWidth(DW), .WordZeroVal('0)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    ibex_rf_wb_arbiter #(.RV32E(1'b1), .DataWidth(DW), .WordZeroVal('0)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".we"},   64'(bus0.rf_we_o), 64'(e.we));
            chk({tag, ".err"},  64'(bus0.err_o),   64'(e.err));
            chk({tag, ".busy"}, 64'(bus0.busy_o),  64'd0);
            if (e.chk_ad) begin
                chk({tag, ".addr"}, 64'(bus0.rf_waddr_o), 64'(e.addr));
                chk({tag, ".data"}, 64'(bus0.rf_wdata_o), 64'(e.data));
            end
        end
    endtask

    // One handshake cycle: drive, check readies mid-cycle, check rf_* after the edge.
    task automatic step(input string tag,
                        input logic va, input logic [4:0] aa, input logic [DW-1:0] da,
                        input logic vb, input logic [4:0] ab, input logic [DW-1:0] db,
                        input logic era, input logic erb);
        exp_t          e;
        logic [4:0]    a;
        logic [DW-1:0] d;
        @(negedge clk);
        bus0.wa_valid_i = va; bus0.wa_addr_i = aa; bus0.wa_data_i = da;
        bus0.wb_valid_i = vb; bus0.wb_addr_i = ab; bus0.wb_data_i = db;
        #1;
        chk({tag, ".ra"}, 64'(bus0.wa_ready_o), 64'(era));
        chk({tag, ".rb"}, 64'(bus0.wb_ready_o), 64'(erb));
        e.err = 1'b0;
        if (era || erb) begin
            a = era ? aa : ab;
            d = era ? da : db;
            e.we = (a != 5'd0); e.addr = a; e.data = d; e.chk_ad = (a != 5'd0);
            if (a != 5'd0) begin
                last_addr = a; last_data = d; known = 1'b1;
            end else begin
                known = 1'b0;
            end
        end else begin
            e.we = 1'b0; e.addr = last_addr; e.data = last_data; e.chk_ad = known;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        pop_check(tag);
    endtask

    task automatic clr_step(input int i);
        @(negedge clk);
        chk($sformatf("clr%0d.busy", i), 64'(bus0.busy_o), 64'd1);
        chk($sformatf("clr%0d.ra", i), 64'(bus0.wa_ready_o), 64'd0);
        chk($sformatf("clr%0d.rb", i), 64'(bus0.wb_ready_o), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("clr%0d.we", i), 64'(bus0.rf_we_o), 64'd1);
        chk($sformatf("clr%0d.addr", i), 64'(bus0.rf_waddr_o), 64'(i));
        chk($sformatf("clr%0d.data", i), 64'(bus0.rf_wdata_o), 64'd0);
    endtask

    task automatic idle_inputs();
        bus0.wa_valid_i = 1'b0; bus0.wa_addr_i = '0; bus0.wa_data_i = '0;
        bus0.wb_valid_i = 1'b0; bus0.wb_addr_i = '0; bus0.wb_data_i = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        chk("rst.we",   64'(bus0.rf_we_o),    64'd0);
        chk("rst.addr", 64'(bus0.rf_waddr_o), 64'd0);
        chk("rst.data", 64'(bus0.rf_wdata_o), 64'd0);
        chk("rst.err",  64'(bus0.err_o),      64'd0);
        chk("rst.busy", 64'(bus0.busy_o),     64'(c_clr));

`ifdef IBEX_RF_CLEAR_EN
        // Requester A holds a request through the whole clear sequence.
        bus0.wa_valid_i = 1'b1; bus0.wa_addr_i = 5'd9; bus0.wa_data_i = 32'h99;
        @(negedge clk) rst = 1'b0;
        for (int i = 1; i <= 9; i++) clr_step(i);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("midclr.we",   64'(bus0.rf_we_o),    64'd0);
        chk("midclr.addr", 64'(bus0.rf_waddr_o), 64'd0);
        chk("midclr.busy", 64'(bus0.busy_o),     64'd1);
        @(negedge clk) rst = 1'b0;
        for (int i = 1; i <= 31; i++) clr_step(i);
        chk("clr.done", 64'(bus0.busy_o), 64'd0);
        last_addr = 5'd31; last_data = '0; known = 1'b1;
        step("post_a", 1, 9, 32'h99, 0, 0, 0, 1, 0);
        step("b10",    0, 0, 0, 1, 10, 32'hAA, 0, 1);
`else
        @(negedge clk) rst = 1'b0;
`endif

        step("tie0", 1, 3, 32'h33, 1, 7, 32'h77, 1, 0);
        step("tie1", 1, 3, 32'h33, 1, 7, 32'h77, 0, 1);
        step("tie2", 1, 3, 32'h33, 1, 7, 32'h77, 1, 0);
        step("tie3", 1, 3, 32'h33, 1, 7, 32'h77, 0, 1);
        step("a5",   1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0);
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        step("bonly", 0, 0, 0, 1, 20, 32'h2020, 0, 1);
        step("x0",   1, 0, 32'h1, 0, 0, 0, 1, 0);
        step("same0", 1, 12, 32'hA1, 1, 12, 32'hB2, 0, 1);
        step("same1", 1, 12, 32'hA1, 0, 0, 0, 1, 0);
        chk("same.final", 64'(bus0.rf_wdata_o), 64'h0A1);

        step("e16", 0, 0, 0, 1, 16, 32'h16, 0, 1);
        chk("e16.we",  64'(bus1.rf_we_o), 64'd0);
        chk("e16.err", 64'(bus1.err_o),   64'd1);
        step("e16b", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("e16b.err", 64'(bus1.err_o), 64'd0);
        step("e15", 1, 15, 32'h15, 0, 0, 0, 1, 0);
        chk("e15.we",   64'(bus1.rf_we_o),    64'd1);
        chk("e15.addr", 64'(bus1.rf_waddr_o), 64'd15);
        chk("e15.err",  64'(bus1.err_o),      64'd0);

`ifndef IBEX_RF_CLEAR_EN
        // Reset in the middle of a contested cycle; the tie pointer must reset too.
        @(negedge clk);
        bus0.wa_valid_i = 1'b1; bus0.wa_addr_i = 5'd3; bus0.wa_data_i = 32'h33;
        bus0.wb_valid_i = 1'b1; bus0.wb_addr_i = 5'd7; bus0.wb_data_i = 32'h77;
        rst = 1'b1;
        #1;
        chk("runrst.we",   64'(bus0.rf_we_o),    64'd0);
        chk("runrst.addr", 64'(bus0.rf_waddr_o), 64'd0);
        chk("runrst.data", 64'(bus0.rf_wdata_o), 64'd0);
        idle_inputs();
        @(negedge clk) rst = 1'b0;
        last_addr = '0; last_data = '0; known = 1'b1;
        step("rst_tie", 1, 3, 32'h33, 1, 7, 32'h77, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
